// File: rtl/serialize_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serialize_arbiter
// Purpose  : Round-robin arbiter sharing one wide-to-narrow serializer among
//            N channels; each beat is tagged {last, id, chunk}.
// Revision : 1.0 - initial release
// ============================================================================
module serialize_arbiter #(
    parameter  int N      = 2,
    parameter  int DIN    = 16,
    parameter  int RETURN = 4,
    localparam int CHUNKS = DIN / RETURN,
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
    localparam int ID_W   = (N > 1) ? $clog2(N) : 1,
    localparam int DOUT_W = RETURN + ID_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N*DIN-1:0]    din_data,
    input  logic [N-1:0]        din_valid,
    output logic [N-1:0]        din_ready,
    output logic [DOUT_W-1:0]   dout_data,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_sel;
    logic [ID_W-1:0]     w_sel_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [ID_W-1:0]     w_grant;
    logic [DIN-1:0]      w_word;
    logic [RETURN-1:0]   w_chunk;
    logic                w_sel_valid;
    logic                w_last;
    logic                w_fire;
    logic                w_any;

    always_comb begin
        w_word      = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_sel == ID_W'(i)) begin
                w_word      = din_data[i*DIN +: DIN];
                w_sel_valid = din_valid[i];
            end
        end
        w_chunk = '0;
        for (int c = 0; c < CHUNKS; c++) begin
            if (r_cnt == CNT_W'(c)) begin
                w_chunk = w_word[c*RETURN +: RETURN];
            end
        end
    end

    // Second pass overrides the first only when a requester exists at or
    // above ptr, giving the circular scan ptr..N-1, 0..ptr-1.
    always_comb begin
        w_grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (din_valid[i]) begin
                w_grant = ID_W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (din_valid[i] && (ID_W'(i) >= r_ptr)) begin
                w_grant = ID_W'(i);
            end
        end
    end

    assign w_any      = |din_valid;
    assign w_last     = (r_cnt == CNT_W'(CHUNKS - 1));
    assign busy       = (r_state == SEND);
    assign dout_valid = (r_state == SEND) && w_sel_valid;
    assign w_fire     = dout_valid && dout_ready;
    assign dout_data  = {w_last, r_sel, w_chunk};

    always_comb begin
        for (int i = 0; i < N; i++) begin
            din_ready[i] = (r_state == SEND) && (r_sel == ID_W'(i)) && dout_ready && w_last;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_sel_nxt   = w_grant;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_fire) begin
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_ptr_nxt   = (r_sel == ID_W'(N - 1)) ? '0 : r_sel + ID_W'(1);
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serialize_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serialize_arbiter
// Purpose  : Scoreboard bench: word-level reference model feeds an expected
//            beat queue; a negedge monitor compares every DUT output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serialize_arbiter;

    logic        clk;
    logic        rst;
    logic [47:0] din_data;
    logic [2:0]  din_valid;
    logic [2:0]  din_ready;
    logic [6:0]  dout_data;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;

    logic [7:0]  d1_data;
    logic [0:0]  d1_valid;
    logic [0:0]  d1_ready;
    logic [9:0]  d1_dout;
    logic        d1_dvalid;
    logic        d1_dready;
    logic        d1_busy;

    serialize_arbiter #(.N(3), .DIN(16), .RETURN(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .din_data   (din_data),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy)
    );

    serialize_arbiter #(.N(1), .DIN(8), .RETURN(8)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .din_data   (d1_data),
        .din_valid  (d1_valid),
        .din_ready  (d1_ready),
        .dout_data  (d1_dout),
        .dout_valid (d1_dvalid),
        .dout_ready (d1_dready),
        .busy       (d1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    bit         mon_en = 1'b0;
    logic [2:0] taken = 3'b000;
    logic [6:0] exp_q[$];

    // Reference model: a grant turns a whole word into four expected beats.
    int m_busy  = 0;
    int m_owner = 0;
    int m_left  = 0;
    int m_ptr   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 0;
                m_ptr  = 0;
                exp_q.delete();
            end else if (m_busy == 0) begin
                if (din_valid != 3'b000) begin
                    int g;
                    bit found;
                    logic [15:0] w;
                    g = 0;
                    found = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        if (!found && din_valid[(m_ptr + k) % 3]) begin
                            g = (m_ptr + k) % 3;
                            found = 1'b1;
                        end
                    end
                    w = din_data[g*16 +: 16];
                    for (int j = 0; j < 4; j++) begin
                        logic [6:0] e;
                        e = {(j == 3) ? 1'b1 : 1'b0, g[1:0], w[j*4 +: 4]};
                        exp_q.push_back(e);
                    end
                    m_busy  = 1;
                    m_owner = g;
                    m_left  = 4;
                end
            end else if (din_valid[m_owner] && dout_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % 3;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                logic [2:0] e_rdy;
                for (int ch = 0; ch < 3; ch++) begin
                    if (din_ready[ch] && din_valid[ch]) taken[ch] = 1'b1;
                end
                e_rdy = (m_busy != 0 && m_left == 1 && dout_ready) ? (3'b001 << m_owner) : 3'b000;
                chk("busy", 32'(busy), 32'(m_busy != 0));
                chk("dout_valid", 32'(dout_valid), 32'(m_busy != 0 && din_valid[m_owner]));
                chk("din_ready", 32'(din_ready), 32'(e_rdy));
                if (dout_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("dout_data_unexpected", 32'(dout_data), 32'hFFFF_FFFF);
                    end else begin
                        chk("dout_data", 32'(dout_data), 32'(exp_q[0]));
                        if (dout_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // mode 0: drop valid when accepted; 1: reload a new word; 2: random traffic
    task automatic cycle(input int mode);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            if (taken[ch]) begin
                taken[ch] = 1'b0;
                if (mode == 1) din_data[ch*16 +: 16] = 16'($urandom);
                else           din_valid[ch] = 1'b0;
            end
        end
        if (mode == 2) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (!din_valid[ch] && $urandom_range(0, 3) == 0) begin
                    din_data[ch*16 +: 16] = 16'($urandom);
                    din_valid[ch] = 1'b1;
                end
            end
            dout_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        dout_ready = 1'b1;
        while ((din_valid != 3'b000 || m_busy != 0) && k < 100) begin
            cycle(0);
            k++;
        end
        chk("drain_timeout", 32'(k < 100), 32'd1);
    endtask

    task automatic d1_chk(input logic v, input logic [9:0] d, input logic r, input logic b);
        @(negedge clk);
        chk("d1_dout_valid", 32'(d1_dvalid), 32'(v));
        chk("d1_din_ready", 32'(d1_ready), 32'(r));
        chk("d1_busy", 32'(d1_busy), 32'(b));
        if (v) chk("d1_dout_data", 32'(d1_dout), 32'(d));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat[7];
        int k;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rst = 1'b1;
        din_data = '0;
        din_valid = '0;
        dout_ready = 1'b0;
        d1_data = '0;
        d1_valid = '0;
        d1_dready = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("d1_busy_reset", 32'(d1_busy), 32'd0);
        chk("d1_ready_reset", 32'(d1_ready), 32'd0);

        // single request on channel 1
        din_data[31:16] = 16'hABCD;
        din_valid = 3'b010;
        dout_ready = 1'b1;
        repeat (8) cycle(0);

        // all channels requesting continuously
        for (int ch = 0; ch < 3; ch++) din_data[ch*16 +: 16] = 16'($urandom);
        din_valid = 3'b111;
        repeat (27) cycle(1);
        drain();

        // backpressure on channel 0
        din_data[15:0] = 16'h1234;
        din_valid = 3'b001;
        cycle(0);
        for (int i = 0; i < 7; i++) begin
            dout_ready = pat[i];
            cycle(0);
        end
        drain();

        // contention raised mid-word
        din_data[15:0] = 16'($urandom);
        din_valid = 3'b001;
        cycle(0);
        cycle(0);
        din_data[47:32] = 16'($urandom);
        din_valid[2] = 1'b1;
        drain();

        // reset while channel 1 is mid-word
        din_data[31:16] = 16'($urandom);
        din_valid = 3'b010;
        k = 0;
        while (!(m_busy != 0 && m_left == 2) && k < 20) begin
            cycle(0);
            k++;
        end
        chk("reset_wait_timeout", 32'(k < 20), 32'd1);
        rst = 1'b1;
        cycle(0);
        drain();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle(2);
            if ($urandom_range(0, 299) == 0 && (m_busy == 0 || m_left > 1)) rst = 1'b1;
        end
        drain();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        // single-channel, single-chunk instance
        @(posedge clk); #1;
        d1_data = 8'h5A;
        d1_valid = 1'b1;
        d1_dready = 1'b1;
        d1_chk(1'b0, 10'h000, 1'b0, 1'b0);
        @(posedge clk); #1;
        d1_chk(1'b1, 10'h25A, 1'b1, 1'b1);
        @(posedge clk); #1;
        d1_data = 8'hC3;
        d1_chk(1'b0, 10'h000, 1'b0, 1'b0);
        @(posedge clk); #1;
        d1_chk(1'b1, 10'h2C3, 1'b1, 1'b1);
        @(posedge clk); #1;
        d1_valid = 1'b0;
        d1_chk(1'b0, 10'h000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serialize_arbiter.md
Name: serialize_arbiter

Overview:
- Shares one DIN-to-RETURN serialization datapath among N requesting channels.
- Round-robin arbitration picks one channel and locks the grant until every chunk of that channel's word has been sent.
- Each output beat is tagged with the source channel id and a last-chunk flag.
- Sits between several wide producers (for example per-lane result buses) and a single narrow link or FIFO.

Parameters:
- N, 2: number of requesting channels; legal range 1 or more.
- DIN, 16: input word width per channel; must be a multiple of RETURN.
- RETURN, 4: output chunk width.
- Derived constants:
  - CHUNKS = DIN/RETURN.
  - CNT_W = max(1, $clog2(CHUNKS)).
  - ID_W = max(1, $clog2(N)).
  - DOUT_W = RETURN+ID_W+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- din_data  in  N*DIN  channel i word occupies bits [(i+1)*DIN-1 : i*DIN].
- din_valid  in  N  per-channel valid.
- din_ready  out  N  per-channel ready; pulses on the handshake of the last chunk only.
- dout_data  out  DOUT_W  {last, id[ID_W-1:0], chunk[RETURN-1:0]}.
- dout_valid  out  1  output valid.
- dout_ready  in  1  output ready.
- busy  out  1  high while a grant is held (state SEND).

Interface: reset rst, synchronous, active-high; clock clk.

Behaviour:
- Handshake rules (dti):
  - A transfer occurs on a cycle where valid & ready are both high.
  - Producers hold valid and data stable until accepted.
  - dout_valid never depends combinationally on dout_ready.
- Registers:
  - state in {IDLE, SEND}.
  - sel [ID_W] is the granted channel.
  - cnt [CNT_W] is the chunk index.
  - ptr [ID_W] is the round-robin start channel.
- Reset values: state=IDLE, sel=0, cnt=0, ptr=0. Hence dout_valid=0, din_ready=all 0, busy=0.
- IDLE:
  - If any din_valid is high, grant the first valid channel scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - On grant: sel<=that channel, cnt<=0, state<=SEND.
  - If no din_valid is high, stay in IDLE.
  - dout_valid=0 in IDLE.
  - Grant latency: first dout_valid appears the cycle after the request is seen in IDLE.
- SEND:
  - dout_valid = din_valid[sel].
  - chunk = din_data word of channel sel, bits [(cnt+1)*RETURN-1 : cnt*RETURN]. Chunks go out LSB chunk first.
  - id = sel.
  - last = (cnt == CHUNKS-1).
- On an output handshake with last=0: cnt<=cnt+1.
- On an output handshake with last=1:
  - cnt<=0.
  - ptr<=(sel==N-1) ? 0 : sel+1.
  - state<=IDLE.
- din_ready[i] = (state==SEND) & (sel==i) & dout_ready & last. It is combinational; all other channels see 0.
- Throughput: CHUNKS beats per word plus one IDLE cycle between consecutive grants.
- Grant lock:
  - No interleaving of chunks from different channels.
  - Requests from other channels raised mid-word wait.
  - Those requests do not disturb sel or cnt.
- Backpressure: while dout_ready=0, cnt, sel and dout_data hold. dout_valid stays high provided the granted producer keeps valid.
- Granted producer dropping din_valid mid-word: this is a protocol violation.
  - dout_valid follows it low.
  - cnt holds.
  - The word resumes when valid returns.
- Fairness: a continuously requesting channel waits at most N-1 words.
- Reset mid-word:
  - The partial word is abandoned and no din_ready is issued.
  - After reset the producer is still valid. It is re-granted per the round robin from ptr=0 and resent from chunk 0.
- CHUNKS=1: every beat has last=1, and each word takes 2 cycles (IDLE+SEND).
- N=1: ID_W=1 and id is always 0.

Test Plan:
- N=3, DIN=16, RETURN=4, single request:
  - Stimulus: ch1 valid with 0xABCD, dout_ready=1.
  - One idle cycle, then beats chunk D,C,B,A, each with id=1.
  - last=1 only on the A beat.
  - din_ready[1]=1 only on that cycle, then busy=0.
- All three channels valid continuously from reset, dout_ready=1:
  - Grant order 0,1,2,0,1.
  - Each grant is 4 beats followed by 1 gap cycle.
  - ptr wraps 2 to 0.
- Backpressure: ch0 word 0x1234, dout_ready toggled 1,0,0,1,0,1,1.
  - Output sequence is 4,3,2,1 with no duplicates or skips.
  - dout_data is stable during stalls.
- Mid-word contention:
  - ch0 is granted; ch2 raises valid at chunk 1.
  - ch0 completes all 4 chunks uninterrupted.
  - ch2 is then granted after 1 idle cycle; ch1 stays idle.
- Reset mid-word:
  - rst asserted for 1 cycle after chunk 2 of ch1.
  - din_ready[1] never pulses.
  - After reset: dout_valid=0, busy=0.
  - Re-grant of ch1 (ptr=0, ch0 not valid) restarts at chunk 0.
- Degenerate N=1, DIN=RETURN=8:
  - Words 0x5A then 0xC3.
  - Each beat has last=1 and id=0.
  - din_ready pulses once per word, with one idle cycle between words.
